// File: rtl/ahb_apb_bridge_ms.sv
// rtl/ahb_apb_bridge_ms.sv - AHB-Lite to APB bridge with address-decoded multi-slave select and optional access timeout
module ahb_apb_bridge_ms #(
    parameter int ADDRWIDTH = 16,
    parameter int NUM_SLV   = 4,
    parameter int SLV_AW    = 12,
    parameter int TIMEOUT   = 0
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    PCLKEN,
    input  logic                    HSEL,
    input  logic                    HWRITE,
    input  logic                    HREADY,
    input  logic [ADDRWIDTH-1:0]    HADDR,
    input  logic [1:0]              HTRANS,
    input  logic [2:0]              HSIZE,
    input  logic [3:0]              HPROT,
    input  logic [31:0]             HWDATA,
    output logic                    HREADYOUT,
    output logic [31:0]             HRDATA,
    output logic                    HRESP,
    output logic [ADDRWIDTH-1:0]    PADDR,
    output logic [NUM_SLV-1:0]      PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [3:0]              PSTRB,
    output logic [2:0]              PPROT,
    output logic [31:0]             PWDATA,
    input  logic [32*NUM_SLV-1:0]   PRDATA,
    input  logic [NUM_SLV-1:0]      PREADY,
    input  logic [NUM_SLV-1:0]      PSLVERR,
    output logic                    APBACTIVE,
    output logic                    PTIMEOUT
);
    localparam int IW = ADDRWIDTH - SLV_AW;
    localparam int NUM_SLV_P = NUM_SLV;
    localparam logic [IW:0] NUM_SLV_W = NUM_SLV_P[IW:0];
    localparam logic [7:0]  TO_LAST   = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT, S_SETUP, S_ACCESS, S_ENDOK, S_ERR1, S_ERR2
    } state_t;

    state_t               state_q, state_d;
    logic [ADDRWIDTH-3:0] addr_q, addr_d;
    logic                 write_q, write_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [2:0]           pprot_q, pprot_d;
    logic [3:0]           pstrb_q, pstrb_d;
    logic [31:0]          pwdata_q, pwdata_d;
    logic [31:0]          hrdata_q, hrdata_d;
    logic [7:0]           to_cnt_q, to_cnt_d;

    logic          sel, idx_bad, pready_s, pslverr_s, timeout_hit;
    logic [IW-1:0] idx_in;
    logic [31:0]   prdata_s;
    logic [3:0]    strb_in;
    logic          unused_inputs;

    assign unused_inputs = ^{HPROT[3:2], HTRANS[0]};
    assign sel     = HSEL & HTRANS[1] & HREADY;
    assign idx_in  = HADDR[ADDRWIDTH-1:SLV_AW];
    assign idx_bad = {1'b0, idx_in} >= NUM_SLV_W;

    always_comb begin
        strb_in = 4'b0000;
        if (HWRITE) begin
            case (HSIZE)
                3'b000:  strb_in = 4'b0001 << HADDR[1:0];
                3'b001:  strb_in = HADDR[1] ? 4'b1100 : 4'b0011;
                default: strb_in = 4'b1111;
            endcase
        end
    end

    // Only the addressed slave's response lines are observed.
    always_comb begin
        pready_s  = 1'b0;
        pslverr_s = 1'b0;
        prdata_s  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (idx_q == IW'(i)) begin
                pready_s  = PREADY[i];
                pslverr_s = PSLVERR[i];
                prdata_s  = PRDATA[32*i +: 32];
            end
        end
    end

    assign timeout_hit = (TIMEOUT > 0) && (state_q == S_ACCESS) && PCLKEN
                         && !pready_s && (to_cnt_q == TO_LAST);

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        write_d  = write_q;
        idx_d    = idx_q;
        pprot_d  = pprot_q;
        pstrb_d  = pstrb_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;
        to_cnt_d = to_cnt_q;
        case (state_q)
            S_IDLE, S_ENDOK, S_ERR2: begin
                state_d = S_IDLE;
                if (sel) begin
                    addr_d  = HADDR[ADDRWIDTH-1:2];
                    write_d = HWRITE;
                    idx_d   = idx_in;
                    pprot_d = {~HPROT[0], 1'b0, HPROT[1]};
                    pstrb_d = strb_in;
                    state_d = idx_bad ? S_ERR1 : S_WAIT;
                end
            end
            S_WAIT: begin
                pwdata_d = HWDATA;
                if (PCLKEN) state_d = S_SETUP;
            end
            S_SETUP: begin
                if (PCLKEN) begin
                    state_d  = S_ACCESS;
                    to_cnt_d = '0;
                end
            end
            S_ACCESS: begin
                if (PCLKEN) begin
                    if (pready_s) begin
                        if (pslverr_s) begin
                            state_d = S_ERR1;
                        end else begin
                            state_d = S_ENDOK;
                            if (!write_q) hrdata_d = prdata_s;
                        end
                    end else if (timeout_hit) begin
                        state_d = S_ERR1;
                    end else if (TIMEOUT > 0) begin
                        to_cnt_d = to_cnt_q + 8'd1;
                    end
                end
            end
            S_ERR1:  state_d = S_ERR2;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            write_q  <= 1'b0;
            idx_q    <= '0;
            pprot_q  <= '0;
            pstrb_q  <= '0;
            pwdata_q <= '0;
            hrdata_q <= '0;
            to_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            write_q  <= write_d;
            idx_q    <= idx_d;
            pprot_q  <= pprot_d;
            pstrb_q  <= pstrb_d;
            pwdata_q <= pwdata_d;
            hrdata_q <= hrdata_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    always_comb begin
        PSEL = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            PSEL[i] = ((state_q == S_SETUP) || (state_q == S_ACCESS)) && (idx_q == IW'(i));
        end
    end

    assign PENABLE   = (state_q == S_ACCESS);
    assign HREADYOUT = (state_q == S_IDLE) || (state_q == S_ENDOK) || (state_q == S_ERR2);
    assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign PADDR     = {addr_q, 2'b00};
    assign PWRITE    = write_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;
    assign PWDATA    = pwdata_q;
    assign HRDATA    = hrdata_q;
    assign APBACTIVE = (HSEL & HTRANS[1]) | (state_q != S_IDLE);
    assign PTIMEOUT  = timeout_hit;
endmodule

// File: tb/tb_ahb_apb_bridge_ms.sv
// tb/tb_ahb_apb_bridge_ms.sv - directed self-checking bench for ahb_apb_bridge_ms
module tb_ahb_apb_bridge_ms;
    logic        HCLK = 1'b0;
    logic        HRESETn, PCLKEN, HWRITE, HREADY, hsel_a, hsel_b;
    logic [15:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;

    logic         a_hreadyout, a_hresp, a_penable, a_pwrite, a_apbactive, a_ptimeout;
    logic [31:0]  a_hrdata, a_pwdata;
    logic [15:0]  a_paddr;
    logic [3:0]   a_psel, a_pstrb, a_pready, a_pslverr;
    logic [2:0]   a_pprot;
    logic [127:0] a_prdata;

    logic         b_hreadyout, b_hresp, b_penable, b_pwrite, b_apbactive, b_ptimeout;
    logic [31:0]  b_hrdata, b_pwdata;
    logic [15:0]  b_paddr;
    logic [2:0]   b_psel, b_pready, b_pslverr, b_pprot;
    logic [3:0]   b_pstrb;
    logic [95:0]  b_prdata;

    int n_cmp = 0;
    int n_err = 0;

    always #5 HCLK = ~HCLK;

    ahb_apb_bridge_ms u_dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN), .HSEL(hsel_a), .HWRITE(HWRITE),
        .HREADY(HREADY), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT),
        .HWDATA(HWDATA), .HREADYOUT(a_hreadyout), .HRDATA(a_hrdata), .HRESP(a_hresp),
        .PADDR(a_paddr), .PSEL(a_psel), .PENABLE(a_penable), .PWRITE(a_pwrite),
        .PSTRB(a_pstrb), .PPROT(a_pprot), .PWDATA(a_pwdata), .PRDATA(a_prdata),
        .PREADY(a_pready), .PSLVERR(a_pslverr), .APBACTIVE(a_apbactive), .PTIMEOUT(a_ptimeout)
    );

    ahb_apb_bridge_ms #(.NUM_SLV(3), .TIMEOUT(4)) u_dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .PCLKEN(PCLKEN), .HSEL(hsel_b), .HWRITE(HWRITE),
        .HREADY(HREADY), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HPROT(HPROT),
        .HWDATA(HWDATA), .HREADYOUT(b_hreadyout), .HRDATA(b_hrdata), .HRESP(b_hresp),
        .PADDR(b_paddr), .PSEL(b_psel), .PENABLE(b_penable), .PWRITE(b_pwrite),
        .PSTRB(b_pstrb), .PPROT(b_pprot), .PWDATA(b_pwdata), .PRDATA(b_prdata),
        .PREADY(b_pready), .PSLVERR(b_pslverr), .APBACTIVE(b_apbactive), .PTIMEOUT(b_ptimeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge HCLK);
        #1;
    endtask

    task automatic req(input logic to_b, input logic [15:0] addr, input logic wr, input logic [2:0] size);
        hsel_a = !to_b;
        hsel_b = to_b;
        HTRANS = 2'b10;
        HADDR  = addr;
        HWRITE = wr;
        HSIZE  = size;
    endtask

    task automatic idle();
        hsel_a = 1'b0;
        hsel_b = 1'b0;
        HTRANS = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        HRESETn = 1'b0; PCLKEN = 1'b1; HREADY = 1'b1; HWRITE = 1'b0;
        hsel_a = 1'b0; hsel_b = 1'b0; HADDR = '0; HTRANS = '0; HSIZE = '0;
        HPROT = 4'b0011; HWDATA = '0;
        a_prdata = '0; a_pready = 4'b1111; a_pslverr = '0;
        b_prdata = '0; b_pready = '0; b_pslverr = '0;
        repeat (2) cyc();
        chk("rst_hreadyout", a_hreadyout, 1);
        chk("rst_hresp", a_hresp, 0);
        chk("rst_psel", a_psel, 0);
        chk("rst_penable", a_penable, 0);
        chk("rst_pwrite", a_pwrite, 0);
        chk("rst_pstrb", a_pstrb, 0);
        chk("rst_paddr", a_paddr, 0);
        chk("rst_pwdata", a_pwdata, 0);
        chk("rst_hrdata", a_hrdata, 0);
        chk("rst_ptimeout", a_ptimeout, 0);
        HRESETn = 1'b1;

        // word write to slave 1
        cyc();
        req(1'b0, 16'h1004, 1'b1, 3'd2);
        #1;
        chk("wr_idle_hreadyout", a_hreadyout, 1);
        chk("wr_apbactive", a_apbactive, 1);
        cyc();
        idle(); HWDATA = 32'hCAFEF00D;
        #1;
        chk("wr_wait_hreadyout", a_hreadyout, 0);
        chk("wr_wait_psel", a_psel, 0);
        cyc();
        chk("wr_setup_psel", a_psel, 4'b0010);
        chk("wr_setup_penable", a_penable, 0);
        chk("wr_paddr", a_paddr, 16'h1004);
        chk("wr_pstrb", a_pstrb, 4'b1111);
        chk("wr_pwdata", a_pwdata, 32'hCAFEF00D);
        chk("wr_pwrite", a_pwrite, 1);
        chk("wr_pprot", a_pprot, 3'b001);
        chk("wr_setup_hreadyout", a_hreadyout, 0);
        cyc();
        chk("wr_access_penable", a_penable, 1);
        chk("wr_access_hreadyout", a_hreadyout, 0);

        // ENDOK; launch read of slave 3 with two wait cycles
        cyc();
        req(1'b0, 16'h3008, 1'b0, 3'd2);
        a_prdata  = {32'h12345678, 32'hDEAD0002, 32'hDEAD0001, 32'hDEAD0000};
        a_pready  = 4'b0111;
        a_pslverr = 4'b0001;
        #1;
        chk("wr_end_hreadyout", a_hreadyout, 1);
        chk("wr_end_hresp", a_hresp, 0);
        cyc();
        idle();
        cyc();
        chk("rd_setup_psel", a_psel, 4'b1000);
        chk("rd_pstrb", a_pstrb, 4'b0000);
        chk("rd_pwrite", a_pwrite, 0);
        chk("rd_paddr", a_paddr, 16'h3008);
        chk("rd_hrdata_held", a_hrdata, 0);
        cyc();
        chk("rd_wait1_hreadyout", a_hreadyout, 0);
        cyc();
        chk("rd_wait2_penable", a_penable, 1);
        chk("rd_wait2_hreadyout", a_hreadyout, 0);
        a_pready = 4'b1111;
        cyc();
        cyc();
        chk("rd_hrdata", a_hrdata, 32'h12345678);
        chk("rd_end_hreadyout", a_hreadyout, 1);
        chk("rd_end_hresp", a_hresp, 0);

        // byte write to 0x0203 with PCLKEN every third cycle
        req(1'b0, 16'h0203, 1'b1, 3'd0);
        PCLKEN = 1'b0; a_pslverr = '0;
        cyc();
        idle(); HWDATA = 32'hA5A5A5A5;
        for (int k = 0; k < 3; k++) begin
            PCLKEN = (k == 2);
            #1;
            chk("slow_wait_psel", a_psel, 0);
            cyc();
        end
        for (int k = 0; k < 3; k++) begin
            PCLKEN = (k == 2);
            #1;
            chk("slow_setup_psel", a_psel, 4'b0001);
            chk("slow_setup_penable", a_penable, 0);
            chk("slow_pstrb", a_pstrb, 4'b1000);
            chk("slow_setup_pwdata", a_pwdata, 32'hA5A5A5A5);
            cyc();
        end
        for (int k = 0; k < 3; k++) begin
            PCLKEN = (k == 2);
            #1;
            chk("slow_access_penable", a_penable, 1);
            chk("slow_access_pwdata", a_pwdata, 32'hA5A5A5A5);
            chk("slow_access_hreadyout", a_hreadyout, 0);
            cyc();
        end
        PCLKEN = 1'b1;
        #1;
        chk("slow_end_hreadyout", a_hreadyout, 1);

        // halfword write answered with PSLVERR
        req(1'b0, 16'h0102, 1'b1, 3'd1);
        a_pslverr = 4'b0001;
        cyc();
        idle(); HWDATA = 32'h11112222;
        cyc();
        chk("half_pstrb", a_pstrb, 4'b1100);
        chk("half_psel", a_psel, 4'b0001);
        cyc();
        cyc();
        chk("slverr_err1_hresp", a_hresp, 1);
        chk("slverr_err1_hreadyout", a_hreadyout, 0);
        chk("slverr_err1_psel", a_psel, 0);
        a_pslverr = '0;
        cyc();
        chk("slverr_err2_hresp", a_hresp, 1);
        chk("slverr_err2_hreadyout", a_hreadyout, 1);
        cyc();
        chk("slverr_idle_hresp", a_hresp, 0);
        chk("idle_apbactive", a_apbactive, 0);

        // reset asserted during ACCESS
        req(1'b0, 16'h1010, 1'b1, 3'd2);
        a_pready = 4'b1101;
        cyc();
        idle(); HWDATA = 32'h55AA55AA;
        cyc();
        cyc();
        chk("rstmid_access_penable", a_penable, 1);
        HRESETn = 1'b0;
        #1;
        chk("rstmid_psel", a_psel, 0);
        chk("rstmid_penable", a_penable, 0);
        chk("rstmid_hreadyout", a_hreadyout, 1);
        chk("rstmid_pwdata", a_pwdata, 0);
        chk("rstmid_paddr", a_paddr, 0);
        chk("rstmid_pstrb", a_pstrb, 0);
        cyc();
        HRESETn = 1'b1; a_pready = 4'b1111;
        cyc();
        chk("post_rst_idle_hreadyout", a_hreadyout, 1);
        chk("post_rst_idle_apbactive", a_apbactive, 0);
        req(1'b0, 16'h2004, 1'b1, 3'd2);
        cyc();
        idle(); HWDATA = 32'h0BADF00D;
        cyc();
        chk("post_rst_psel", a_psel, 4'b0100);
        cyc();
        cyc();
        chk("post_rst_end_hreadyout", a_hreadyout, 1);
        chk("post_rst_end_hresp", a_hresp, 0);
        chk("post_rst_pwdata", a_pwdata, 32'h0BADF00D);

        // NUM_SLV=3 instance: decode error on 0x3000
        req(1'b1, 16'h3000, 1'b1, 3'd2);
        #1;
        chk("dec_apbactive", b_apbactive, 1);
        cyc();
        idle();
        #1;
        chk("dec_err1_psel", b_psel, 0);
        chk("dec_err1_hresp", b_hresp, 1);
        chk("dec_err1_hreadyout", b_hreadyout, 0);
        cyc();
        chk("dec_err2_hresp", b_hresp, 1);
        chk("dec_err2_hreadyout", b_hreadyout, 1);

        // TIMEOUT=4 instance: slave 1 never ready
        req(1'b1, 16'h1000, 1'b1, 3'd2);
        cyc();
        idle();
        cyc();
        chk("to_setup_psel", b_psel, 3'b010);
        cyc();
        for (int k = 0; k < 4; k++) begin
            chk("to_access_ptimeout", b_ptimeout, (k == 3) ? 1 : 0);
            chk("to_access_psel", b_psel, 3'b010);
            chk("to_access_penable", b_penable, 1);
            cyc();
        end
        chk("to_err1_psel", b_psel, 0);
        chk("to_err1_penable", b_penable, 0);
        chk("to_err1_ptimeout", b_ptimeout, 0);
        chk("to_err1_hresp", b_hresp, 1);
        chk("to_err1_hreadyout", b_hreadyout, 0);
        cyc();
        chk("to_err2_hresp", b_hresp, 1);
        chk("to_err2_hreadyout", b_hreadyout, 1);
        cyc();
        chk("to_idle_hresp", b_hresp, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/ahb_apb_bridge_ms.md
AHB_APB_BRIDGE_MS -- requirements
Module: ahb_apb_bridge_ms

Interface
REQ-001 Parameters: ADDRWIDTH, default 16, AHB/APB address width; NUM_SLV, default 4, number of APB slaves (1..16); SLV_AW, default 12, log2 bytes per slave region; TIMEOUT, default 0, PCLKEN-qualified access-phase wait limit (0 = disabled, else 2..255).
REQ-002 Ports (name  direction  width  meaning):
- HCLK  in  1  clock
- HRESETn  in  1  asynchronous active-low reset
- PCLKEN  in  1  APB clock enable
- HSEL, HWRITE, HREADY  in  1  AHB select, write, ready-in
- HADDR  in  ADDRWIDTH  AHB address
- HTRANS  in  2  transfer type
- HSIZE  in  3  transfer size
- HPROT  in  4  protection
- HWDATA  in  32  write data
- HREADYOUT  out  1  ready
- HRDATA  out  32  read data
- HRESP  out  1  error response
- PADDR  out  ADDRWIDTH  APB address, bits [1:0] = 0
- PSEL  out  NUM_SLV  one-hot slave select
- PENABLE, PWRITE  out  1  APB enable, write
- PSTRB  out  4  byte strobes
- PPROT  out  3  {~HPROT[0], 0, HPROT[1]}
- PWDATA  out  32  registered write data
- PRDATA  in  32*NUM_SLV  read data, slave i at [32i+31:32i]
- PREADY, PSLVERR  in  NUM_SLV  per-slave ready, error
- APBACTIVE  out  1  (HSEL & HTRANS[1]) | state != IDLE
- PTIMEOUT  out  1  one-cycle pulse on timeout abort

Function
REQ-003 sel = HSEL & HTRANS[1] & HREADY; idx = HADDR[ADDRWIDTH-1:SLV_AW]; decode error when idx >= NUM_SLV.
REQ-004 On sel: register HADDR[ADDRWIDTH-1:2], HWRITE, idx, PPROT, and PSTRB (word: 1111; half: 0011/1100 by HADDR[1]; byte: one-hot by HADDR[1:0]; reads: 0000).
REQ-005 States: IDLE, WAIT, SETUP, ACCESS, ENDOK, ERR1, ERR2.
REQ-006 IDLE/ENDOK/ERR2: sel with valid idx -> WAIT; sel with bad idx -> ERR1, no PSEL asserted; else -> IDLE.
REQ-007 WAIT: PWDATA <= HWDATA every cycle; -> SETUP when PCLKEN=1, else stay.
REQ-008 SETUP: PSEL[idx]=1, PENABLE=0; -> ACCESS when PCLKEN=1.
REQ-009 ACCESS: PSEL[idx]=1, PENABLE=1; advances only on PCLKEN=1; PREADY[idx]&~PSLVERR[idx] -> ENDOK, HRDATA register <= PRDATA slice idx on reads (held on writes); PREADY[idx]&PSLVERR[idx] -> ERR1.
REQ-010 Timeout (TIMEOUT>0): counter cleared on SETUP->ACCESS, increments each PCLKEN=1 ACCESS cycle with PREADY[idx]=0; on reaching TIMEOUT-1 with PREADY[idx]=0 and PCLKEN=1 -> ERR1, PTIMEOUT=1 that cycle, PSEL/PENABLE low from the next cycle.
REQ-011 ERR1 -> ERR2 unconditionally.
REQ-012 HREADYOUT: 1 in IDLE, ENDOK, ERR2; 0 otherwise. HRESP: 1 in ERR1, ERR2 only.
REQ-013 PSEL is all-zero outside SETUP/ACCESS; at most one bit set.
REQ-014 Unselected slaves' PREADY/PSLVERR/PRDATA have no effect.
REQ-015 Sel in a state other than IDLE/ENDOK/ERR2 is ignored; it cannot occur under AHB rules.

Reset
REQ-016 HRESETn low asynchronously forces IDLE; HREADYOUT=1, HRESP=0, PSEL=0, PENABLE=0, PWRITE=0, PSTRB=0, PADDR=0, PWDATA=0, HRDATA=0, PTIMEOUT=0, timeout counter=0.
REQ-017 Reset mid-transfer drops PSEL/PENABLE immediately; the first post-reset cycle is IDLE.

Verification
REQ-018 PCLKEN=1, word write 0x1004 = 0xCAFEF00D -> PSEL=0010, PADDR=0x1004, PSTRB=1111, PWDATA=0xCAFEF00D; HREADYOUT low 3 cycles, then HRESP=0.
REQ-019 Read 0x3008, slave 3 PRDATA=0x12345678, PREADY low 2 PCLKEN cycles -> HRDATA=0x12345678 in ENDOK, HREADYOUT=1.
REQ-020 NUM_SLV=3, access to 0x3000 -> no PSEL, HRESP=1 for 2 cycles, HREADYOUT 0 then 1.
REQ-021 TIMEOUT=4, PREADY held 0 -> PTIMEOUT pulse after 4th ACCESS PCLKEN cycle, PSEL cleared, two-cycle ERROR response.
REQ-022 PCLKEN high every 3rd cycle, byte write at 0x0203 -> PSTRB=1000; SETUP/ACCESS each last 3 HCLKs; PWDATA stable throughout.
REQ-023 HRESETn pulsed low during ACCESS -> all outputs at reset values within the same cycle; the next transfer completes normally.
